// File: rtl/int_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_arith_pkg
// Description : Shared constants and types for the Int_Add integer datapath.
//               Holds the word/half widths, the lookahead group size, and the
//               result-flag bundle. The subtractor fills in bout/ovf/zero; the
//               adder reuses the same bundle with bout read as its carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
package int_arith_pkg;

  localparam int WORD_W  = 32;  // full operand width
  localparam int HALF_W  = 16;  // width handled by one pipeline stage
  localparam int GROUP_W = 4;   // lookahead group size inside a CLA half

  // Result flags. For the adder the first field carries cout.
  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
  } arith_flags_t;

endpackage : int_arith_pkg
`default_nettype wire

// File: rtl/cla_16_bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_16_bit
// Description : Purely combinational 16-bit carry-lookahead adder.
//               sum = a + b + cin, cout = carry out of bit 15.
//               Bits are grouped in fours. Each group forms a group
//               generate/propagate pair. Group carries come from those pairs,
//               and bit carries inside a group are expanded in lookahead
//               form from the group carry-in.
// Ports       : sum  [15:0] out  - sum bits
//               cout        out  - carry out of the MSB
//               a    [15:0] in   - addend
//               b    [15:0] in   - addend
//               cin         in   - carry in
// Revision    : 1.0 - initial release
// ============================================================================
module cla_16_bit
  import int_arith_pkg::*;
(
  output logic [HALF_W-1:0] sum,
  output logic              cout,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin
);

  localparam int NUM_GROUPS = HALF_W / GROUP_W;

  logic [HALF_W-1:0]     g;   // bit generate
  logic [HALF_W-1:0]     p;   // bit propagate
  logic [HALF_W-1:0]     c;   // carry into each bit
  logic [NUM_GROUPS-1:0] gg;  // group generate
  logic [NUM_GROUPS-1:0] gp;  // group propagate
  logic [NUM_GROUPS:0]   gc;  // carry into each group (gc[NUM_GROUPS] = cout)

  for (genvar i = 0; i < HALF_W; i++) begin : g_bit
    assign g[i] = a[i] & b[i];
    assign p[i] = a[i] ^ b[i];
  end

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
    localparam int LSB = k * GROUP_W;

    assign gg[k] = g[LSB+3]
                 | (p[LSB+3] & g[LSB+2])
                 | (p[LSB+3] & p[LSB+2] & g[LSB+1])
                 | (p[LSB+3] & p[LSB+2] & p[LSB+1] & g[LSB]);
    assign gp[k] = &p[LSB+3:LSB];

    // In-group carries, fully expanded from the group carry-in.
    assign c[LSB]   = gc[k];
    assign c[LSB+1] = g[LSB] | (p[LSB] & gc[k]);
    assign c[LSB+2] = g[LSB+1]
                    | (p[LSB+1] & g[LSB])
                    | (p[LSB+1] & p[LSB] & gc[k]);
    assign c[LSB+3] = g[LSB+2]
                    | (p[LSB+2] & g[LSB+1])
                    | (p[LSB+2] & p[LSB+1] & g[LSB])
                    | (p[LSB+2] & p[LSB+1] & p[LSB] & gc[k]);
  end

  // Group-level carries from the group generate/propagate pairs.
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NUM_GROUPS];

endmodule : cla_16_bit
`default_nettype wire

// File: rtl/int_sub_32.sv
`default_nettype none
// ============================================================================
// Module      : int_sub_32
// Description : Two-stage pipelined 32-bit subtractor, diff = a - b - bin.
//               The operation is computed as a + ~b + ~bin.
//               Stage 1 produces the low half with one 16-bit CLA and keeps
//               what the upper half needs.
//               Stage 2 produces the high half and the borrow, overflow and
//               zero flags.
//               valid/ready on both sides; up to two results in flight.
// Ports       : clk        in   - clock, rising edge
//               rst        in   - synchronous active-high reset
//               in_valid   in   - operands valid
//               in_ready   out  - stage 1 can accept
//               a   [31:0] in   - minuend
//               b   [31:0] in   - subtrahend
//               bin        in   - borrow in
//               out_valid  out  - result valid
//               out_ready  in   - consumer accepts result
//               diff[31:0] out  - a - b - bin mod 2^32
//               bout       out  - unsigned borrow out
//               ovf        out  - signed overflow
//               zero       out  - diff == 0
// Revision    : 1.0 - initial release
// ============================================================================
module int_sub_32
  import int_arith_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // --------------------------------------------------------------------------
  // Stage 1 state
  // --------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [HALF_W-1:0] lo_diff_q,  lo_diff_d;
  logic              c16_q,      c16_d;
  logic [HALF_W-1:0] a_hi_q,     a_hi_d;
  logic [HALF_W-1:0] nb_hi_q,    nb_hi_d;   // already inverted subtrahend
  logic              a_msb_q,    a_msb_d;
  logic              b_msb_q,    b_msb_d;

  // --------------------------------------------------------------------------
  // Stage 2 (output) state
  // --------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  diff_q,      diff_d;
  arith_flags_t      flags_q,     flags_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s2_advance;
  logic in_fire;

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign in_fire    = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Arithmetic: one CLA half per stage
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  b_inv;
  logic [HALF_W-1:0] lo_sum;
  logic              lo_cout;
  logic [HALF_W-1:0] hi_sum;
  logic              hi_cout;

  assign b_inv = ~b;

  cla_16_bit u_cla_lo (
    .sum  (lo_sum),
    .cout (lo_cout),
    .a    (a[HALF_W-1:0]),
    .b    (b_inv[HALF_W-1:0]),
    .cin  (~bin)
  );

  cla_16_bit u_cla_hi (
    .sum  (hi_sum),
    .cout (hi_cout),
    .a    (a_hi_q),
    .b    (nb_hi_q),
    .cin  (c16_q)
  );

  // --------------------------------------------------------------------------
  // Stage 1 next state. Operand capture only on an actual transfer, so
  // idle values on a/b/bin never reach the pipeline.
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    lo_diff_d  = lo_diff_q;
    c16_d      = c16_q;
    a_hi_d     = a_hi_q;
    nb_hi_d    = nb_hi_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end

    if (in_fire) begin
      lo_diff_d = lo_sum;
      c16_d     = lo_cout;
      a_hi_d    = a[WIDTH-1:HALF_W];
      nb_hi_d   = b_inv[WIDTH-1:HALF_W];
      a_msb_d   = a[WIDTH-1];
      b_msb_d   = b[WIDTH-1];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 next state. The result and flags hold whenever the output is
  // stalled or stage 1 is empty.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] full_diff;

  assign full_diff = {hi_sum, lo_diff_q};

  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    flags_d     = flags_q;

    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d       = full_diff;
        // No carry out of a + ~b + ~bin means the subtraction borrowed.
        flags_d.bout = ~hi_cout;
        // Overflow is only possible when the operand signs differ, and
        // shows up as a result whose sign differs from the minuend.
        flags_d.ovf  = (a_msb_q != b_msb_q) && (hi_sum[HALF_W-1] != a_msb_q);
        flags_d.zero = (full_diff == '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_diff_q   <= '0;
      c16_q       <= 1'b0;
      a_hi_q      <= '0;
      nb_hi_q     <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_diff_q   <= lo_diff_d;
      c16_q       <= c16_d;
      a_hi_q      <= a_hi_d;
      nb_hi_q     <= nb_hi_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = flags_q.bout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule : int_sub_32
`default_nettype wire

// File: tb/tb_int_sub_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_sub_32
// Description : Self-checking bench for int_sub_32. Expected results come from
//               a 33-bit / 64-bit arithmetic reference of a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_sub_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_sub_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: returns {bout, ovf, zero, diff}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic bi);
    logic [32:0] r;
    longint      s;
    logic        m_ovf;
    r     = {1'b0, x} - {1'b0, y} - {32'd0, bi};
    s     = longint'($signed(x)) - longint'($signed(y)) - (bi ? 64'sd1 : 64'sd0);
    m_ovf = (s != longint'($signed(r[31:0])));
    return {r[32], m_ovf, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  function automatic logic [34:0] observed();
    return {bout, ovf, zero, diff};
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'hdead_beef; b = 32'h1234_5678; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (observed() !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // Idle inputs must not create a result.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_result: got out_valid=%b want 0", out_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_directed();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic        tbi[5];
    logic [34:0] te [5];
    ta[0] = 32'hffff_ffd9; tb[0] = 32'h0000_0062; tbi[0] = 1'b0; te[0] = {3'b000, 32'hffff_ff77};
    ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001; tbi[1] = 1'b0; te[1] = {3'b100, 32'hffff_ffff};
    ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001; tbi[2] = 1'b0; te[2] = {3'b010, 32'h7fff_ffff};
    ta[3] = 32'h0000_0005; tb[3] = 32'h0000_0005; tbi[3] = 1'b0; te[3] = {3'b001, 32'h0000_0000};
    ta[4] = 32'h0001_0000; tb[4] = 32'h0000_0000; tbi[4] = 1'b1; te[4] = {3'b000, 32'h0000_ffff};
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; bin = tbi[i]; in_valid = 1'b1; out_ready = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      a = 32'h5555_aaaa; b = 32'haaaa_5555;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_latency: got out_valid=%b want 1", i, out_valid);
      end
      n_checks++;
      if (observed() !== te[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result: got {bout,ovf,zero,diff}=%h want %h", i, observed(), te[i]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_drain: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [31:0] oa[4];
    logic [31:0] ob[4];
    logic        obi[4];
    logic [34:0] oe[4];
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      oa[i] = $urandom; ob[i] = $urandom; obi[i] = 1'($urandom_range(0, 1));
      oe[i] = model(oa[i], ob[i], obi[i]);
    end
    a = oa[0]; b = ob[0]; bin = obi[0]; in_valid = 1'b1; out_ready = 1'b0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      if (cyc < 5) begin
        n_checks++;
        if (in_ready !== (idx < 2)) begin
          n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, (idx < 2));
        end
        if (out_valid === 1'b1) begin
          n_checks++;
          if (observed() !== oe[0]) begin
            n_fail++; $display("FAIL bp_stall_hold cyc%0d: got %h want %h", cyc, observed(), oe[0]);
          end
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_one_per_cycle cyc%0d: got out_valid=%b want 1", cyc, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (observed() !== oe[got]) begin
          n_fail++; $display("FAIL bp_order res%0d: got %h want %h", got, observed(), oe[got]);
        end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          a = oa[idx]; b = ob[idx]; bin = obi[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
      if (cyc == 5) out_ready = 1'b1;
    end
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL bp_timeout: got %0d results want 4", got);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h0000_1000; b = 32'h0000_0001; bin = 1'b0;
    @(posedge clk);
    #1 a = 32'h7777_0000; b = 32'h1111_1111;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== 35'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got out_valid=%b res=%h in_ready=%b want 0 0 1",
               out_valid, observed(), in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stale cyc%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] exp_r;
    logic [34:0] held = '0;
    logic        hold_valid = 1'b0;
    int accepted = 0;
    int cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (accepted < 10000 && cyc < 60000) begin
      @(negedge clk);
      if (hold_valid) begin
        n_checks++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          n_fail++;
          $display("FAIL rnd_stall_hold cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, observed(), held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected cyc%0d: got %h want none", cyc, observed());
        end else begin
          exp_r = q.pop_front();
          if (observed() !== exp_r) begin
            n_fail++; $display("FAIL rnd_result cyc%0d: got %h want %h", cyc, observed(), exp_r);
          end
        end
        hold_valid = 1'b0;
      end else if (out_valid === 1'b1) begin
        hold_valid = 1'b1;
        held = observed();
      end else begin
        hold_valid = 1'b0;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        q.push_back(model(a, b, bin));
        accepted++;
      end
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = $urandom;
      b   = $urandom;
      bin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) b = a;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_checks++;
        exp_r = q.pop_front();
        if (observed() !== exp_r) begin
          n_fail++; $display("FAIL rnd_drain: got %h want %h", observed(), exp_r);
        end
      end
    end
    n_checks++;
    if (q.size() != 0 || accepted != 10000) begin
      n_fail++;
      $display("FAIL rnd_complete: got pending=%0d accepted=%0d want 0 10000", q.size(), accepted);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_int_sub_32
`default_nettype wire
